// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// Latency: 33 edges from start to DoneE for iterative ops, 1 edge for early-out ops.
// Backpressure: BusyE (combinational) stalls F/D/E while an op iterates; StartE is ignored outside IDLE.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   StartE, FlushE  start a new M-op / abort any op in flight
//   MulDivOpE       funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   SrcAE, SrcBE    rs1 / rs2 operands after forwarding
//   BusyE           stall request to the hazard unit
//   DoneE, ResultE  one-cycle completion pulse and registered result
//
// Build option: define MULDIV_FAST_MUL_EN to complete all multiplies in one
// cycle through a 33x33 signed multiplier; divides still iterate.
module execute_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      MulDivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  opReg;
    logic        negFlag;    // final result must be negated
    logic [31:0] bReg;       // multiplicand or divisor magnitude
    logic [63:0] acc;        // mul: {partial product, multiplier}; div: {rem, quot}
    logic [5:0]  count;

    // ---------------- start-time decode on the incoming operands
    logic        isDivIn;
    logic        aSigned;
    logic        bSigned;
    logic        signA;
    logic        signB;
    logic [31:0] aMagIn;
    logic [31:0] bMagIn;
    logic        negIn;
    logic        divZero;
    logic        divOvf;
    logic        mulEarly;
    logic        earlyOut;
    logic [31:0] earlyRes;
    logic [31:0] divEarlyRes;

    assign isDivIn = MulDivOpE[2];
    assign aSigned = (MulDivOpE == 3'b001) || (MulDivOpE == 3'b010) ||
                     (MulDivOpE == 3'b100) || (MulDivOpE == 3'b110);
    assign bSigned = (MulDivOpE == 3'b001) || (MulDivOpE == 3'b100) ||
                     (MulDivOpE == 3'b110);
    assign signA   = aSigned & SrcAE[31];
    assign signB   = bSigned & SrcBE[31];
    assign aMagIn  = signA ? (32'd0 - SrcAE) : SrcAE;
    assign bMagIn  = signB ? (32'd0 - SrcBE) : SrcBE;
    // Remainder takes the dividend's sign; quotient and products take the xor.
    assign negIn   = (isDivIn && MulDivOpE[1]) ? signA : (signA ^ signB);

    assign divZero = isDivIn && (SrcBE == 32'd0);
    assign divOvf  = isDivIn && !MulDivOpE[0] &&
                     (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
    assign divEarlyRes = divZero ? (MulDivOpE[1] ? SrcAE : 32'hFFFF_FFFF)
                                 : (MulDivOpE[1] ? 32'd0 : 32'h8000_0000);

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending both operands to 64 bits gives the exact 33x33 signed
    // product in the low 64 bits of the multiply.
    logic [63:0] aExt;
    logic [63:0] bExt;
    logic [63:0] fastProd;
    logic [31:0] fastRes;

    assign aExt     = {{32{signA}}, SrcAE};
    assign bExt     = {{32{signB}}, SrcBE};
    assign fastProd = aExt * bExt;
    assign fastRes  = (MulDivOpE == 3'b000) ? fastProd[31:0] : fastProd[63:32];
    assign mulEarly = !isDivIn;
    assign earlyRes = isDivIn ? divEarlyRes : fastRes;
`else
    assign mulEarly = 1'b0;
    assign earlyRes = divEarlyRes;
`endif

    assign earlyOut = divZero || divOvf || mulEarly;

    // ---------------- one iteration step
    logic [32:0] mulSum;
    logic [63:0] mulNext;
    logic [32:0] divShift;
    logic        divFits;
    logic [31:0] divDiff;
    logic [63:0] divNext;
    logic [63:0] accNext;
    logic [63:0] mulFinal;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;
    logic [31:0] calcRes;

    assign mulSum  = acc[0] ? ({1'b0, acc[63:32]} + {1'b0, bReg}) : {1'b0, acc[63:32]};
    assign mulNext = {mulSum, acc[31:1]};

    // Partial remainder stays below the divisor, so the shifted value fits in
    // 33 bits and a successful subtract always fits back in 32.
    assign divShift = {acc[63:32], acc[31]};
    assign divFits  = (divShift >= {1'b0, bReg});
    assign divDiff  = divShift[31:0] - bReg;
    assign divNext  = divFits ? {divDiff, acc[30:0], 1'b1}
                              : {divShift[31:0], acc[30:0], 1'b0};

    assign accNext  = opReg[2] ? divNext : mulNext;

    // Sign correction applied on the last iteration, straight into ResultE.
    assign mulFinal  = negFlag ? (64'd0 - accNext) : accNext;
    assign quotFinal = negFlag ? (32'd0 - accNext[31:0]) : accNext[31:0];
    assign remFinal  = negFlag ? (32'd0 - accNext[63:32]) : accNext[63:32];

    always_comb begin
        calcRes = 32'd0;
        case (opReg)
            3'b000:                 calcRes = mulFinal[31:0];
            3'b001, 3'b010, 3'b011: calcRes = mulFinal[63:32];
            3'b100, 3'b101:         calcRes = quotFinal;
            default:                calcRes = remFinal;
        endcase
    end

    assign BusyE = rst && ((state == CALC) ||
                           ((state == IDLE) && StartE && !FlushE && !earlyOut));

    // ---------------- control
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            opReg   <= 3'd0;
            negFlag <= 1'b0;
            bReg    <= 32'd0;
            acc     <= 64'd0;
            count   <= 6'd0;
            DoneE   <= 1'b0;
            ResultE <= '0;
        end else begin
            DoneE <= 1'b0;
            case (state)
                IDLE: begin
                    if (StartE && !FlushE) begin
                        if (earlyOut) begin
                            state   <= DONE;
                            ResultE <= earlyRes;
                            DoneE   <= 1'b1;
                        end else begin
                            state   <= CALC;
                            opReg   <= MulDivOpE;
                            negFlag <= negIn;
                            bReg    <= bMagIn;
                            acc     <= {32'd0, aMagIn};
                            count   <= 6'd0;
                        end
                    end
                end
                CALC: begin
                    if (FlushE) begin
                        state <= IDLE;
                    end else begin
                        acc   <= accNext;
                        count <= count + 6'd1;
                        if (count == 6'd31) begin
                            state   <= DONE;
                            ResultE <= calcRes;
                            DoneE   <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // EX advances to a new instruction; any StartE here is stale.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Self-checking bench for execute_muldiv_unit: directed cases plus random ops
// compared against an arithmetic reference model of the RV32M rules.
module tb_execute_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        StartE;
    logic        FlushE;
    logic [2:0]  MulDivOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] ResultE;

    int checks = 0;
    int errors = 0;

    execute_muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .StartE    (StartE),
        .FlushE    (FlushE),
        .MulDivOpE (MulDivOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .BusyE     (BusyE),
        .DoneE     (DoneE),
        .ResultE   (ResultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension results computed with wide arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        int          ia, ib;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ia = a;
        ib = b;
        case (op)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = sa * sb; return p[63:32]; end
            3'b010: begin p = sa * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit isEarly(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 1'b1;
`endif
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Called at negedge+1; returns at negedge+1 one cycle after DoneE.
    task automatic runOp(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [31:0] exp;
        bit          early;
        int          cycles;
        int          busyCnt;
        exp   = model(op, a, b);
        early = isEarly(op, a, b);
        StartE = 1'b1; MulDivOpE = op; SrcAE = a; SrcBE = b;
        #1;
        busyCnt = BusyE ? 1 : 0;
        @(negedge clk); #1;
        StartE = 1'b0; SrcAE = $urandom; SrcBE = $urandom;
        cycles = 1;
        while (!DoneE && cycles < 40) begin
            busyCnt += BusyE ? 1 : 0;
            @(negedge clk); #1;
            cycles++;
        end
        chk({tag, ".lat"}, cycles, early ? 1 : 33);
        chk({tag, ".busy"}, busyCnt, early ? 0 : 33);
        chk({tag, ".busyAtDone"}, {31'd0, BusyE}, 32'd0);
        chk({tag, ".res"}, ResultE, exp);
        @(negedge clk); #1;
        chk({tag, ".pulse"}, {31'd0, DoneE}, 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        int          doneSeen;
        rst = 1'b0; StartE = 1'b0; FlushE = 1'b0;
        MulDivOpE = 3'd0; SrcAE = 32'd0; SrcBE = 32'd0;
        #2;
        chk("reset.busy", {31'd0, BusyE}, 32'd0);
        chk("reset.done", {31'd0, DoneE}, 32'd0);
        chk("reset.res", ResultE, 32'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;

        runOp("mul", 3'b000, 32'd7, 32'hFFFF_FFFD);
        chk("mul.const", ResultE, 32'hFFFF_FFEB);
        runOp("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000);
        chk("mulh.const", ResultE, 32'h4000_0000);
        runOp("mulhu", 3'b011, 32'h8000_0000, 32'h8000_0000);
        chk("mulhu.const", ResultE, 32'h4000_0000);
        runOp("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2);
        chk("mulhsu.const", ResultE, 32'hFFFF_FFFF);
        runOp("div", 3'b100, 32'hFFFF_FFF9, 32'd2);
        chk("div.const", ResultE, 32'hFFFF_FFFD);
        runOp("rem", 3'b110, 32'hFFFF_FFF9, 32'd2);
        chk("rem.const", ResultE, 32'hFFFF_FFFF);
        runOp("divu", 3'b101, 32'hFFFF_FFF9, 32'd2);
        chk("divu.const", ResultE, 32'h7FFF_FFFC);
        runOp("div0", 3'b100, 32'd5, 32'd0);
        chk("div0.const", ResultE, 32'hFFFF_FFFF);
        runOp("remu0", 3'b111, 32'd5, 32'd0);
        chk("remu0.const", ResultE, 32'd5);
        runOp("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("divovf.const", ResultE, 32'h8000_0000);
        runOp("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

        // Abort a divide part-way through.
        prev = ResultE;
        StartE = 1'b1; MulDivOpE = 3'b101; SrcAE = 32'd100; SrcBE = 32'd3;
        @(negedge clk); #1;
        StartE = 1'b0;
        repeat (10) begin
            @(negedge clk); #1;
        end
        chk("abort.busyBefore", {31'd0, BusyE}, 32'd1);
        FlushE = 1'b1;
        @(negedge clk); #1;
        FlushE = 1'b0;
        chk("abort.busy", {31'd0, BusyE}, 32'd0);
        chk("abort.res", ResultE, prev);
        doneSeen = 0;
        repeat (36) begin
            doneSeen += DoneE ? 1 : 0;
            @(negedge clk); #1;
        end
        chk("abort.noDone", doneSeen, 0);
        chk("abort.resHeld", ResultE, prev);
        runOp("remuAfterAbort", 3'b111, 32'd100, 32'd3);
        chk("remuAfterAbort.const", ResultE, 32'd1);

        // Reset in the middle of a multiply-or-divide iteration.
        StartE = 1'b1; MulDivOpE = 3'b101; SrcAE = 32'h1234_5678; SrcBE = 32'd7;
        @(negedge clk); #1;
        StartE = 1'b0;
        repeat (5) begin
            @(negedge clk); #1;
        end
        rst = 1'b0;
        #1;
        chk("midReset.busy", {31'd0, BusyE}, 32'd0);
        chk("midReset.done", {31'd0, DoneE}, 32'd0);
        chk("midReset.res", ResultE, 32'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        @(negedge clk); #1;
        runOp("mulZero", 3'b000, 32'd0, 32'd0);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            runOp($sformatf("rand%0d_op%0d", i, op), op, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/execute_muldiv_unit.md
# execute_muldiv_unit

Iterative RV32M multiply/divide unit in the Execute stage, fed by the ID/EX pipeline register alongside the main ALU. It accepts one M-extension operation at a time, holds the front of the pipeline via a busy signal while it iterates, and presents a registered 32-bit result for the EX/MEM register. Shift-add multiply and restoring divide each take 32 iterations. Divide-by-zero and signed overflow complete early.

## Interface
- XLEN, 32: operand/result width; only 32 is supported.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low; when low, all state and outputs clear.
- StartE  input  1  valid M-extension operation in EX this cycle.
- FlushE  input  1  flush of EX; aborts any operation in flight.
- MulDivOpE  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcAE  input  32  rs1 operand after forwarding.
- SrcBE  input  32  rs2 operand after forwarding.
- BusyE  output  1  combinational; drives StallF/StallD/StallE in the hazard unit.
- DoneE  output  1  registered; one-cycle pulse, ResultE valid.
- ResultE  output  32  registered result; holds its value until the next DONE.

## Operation
- States:
  - IDLE: waits for an operation.
  - CALC: iterates.
  - DONE: presents the result.
- IDLE -> CALC when StartE=1 and FlushE=0:
  - Latch op, sign flags, |SrcAE|, |SrcBE|.
  - Clear the 6-bit iteration counter.
- Operand sign handling:
  - Signed operands: MULH rs1/rs2, MULHSU rs1 only, DIV/REM both.
  - Unsigned iteration is performed on the magnitudes; the result is negated on the CALC->DONE edge if required.
- IDLE -> DONE directly (early out) when StartE=1, FlushE=0 and either:
  - Divisor is 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> SrcAE.
  - DIV/REM with SrcAE=0x80000000 and SrcBE=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- CALC multiply: each cycle, if multiplier LSB is 1, add the multiplicand into the upper half of a 64-bit accumulator, then shift right 1.
  - MUL returns the low 32 bits.
  - MULH/MULHSU/MULHU return the high 32 bits of the signed-corrected 64-bit product.
- CALC divide: restoring; each cycle shift {rem,quot} left 1, trial-subtract divisor, set quotient bit on no borrow.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- CALC -> DONE after counter reaches 31, i.e. after 32 iterations.
- DONE -> IDLE unconditionally next edge. StartE in DONE is ignored (EX is advancing to a new instruction next cycle).
- BusyE = (state==CALC) | (state==IDLE & StartE & ~FlushE & ~early_out).
- StartE while in CALC is ignored. The stall guarantees EX contents are unchanged.
- FlushE=1 in any state -> IDLE on the next edge, with no DoneE and ResultE unchanged.
- Reset (rst=0): state=IDLE, counter=0, DoneE=0, ResultE=0, accumulators=0; BusyE=0. Reset mid-operation discards the operation.

## Timing
- Start sampled at edge 0.
- Iterative ops: CALC covers edges 1..32; DONE is entered at edge 32. DoneE=1 and ResultE are valid in the cycle after edge 32, and BusyE=0 in that cycle so the EX/MEM register captures ResultE at edge 33.
- Early-out ops: DONE entered at edge 0; DoneE high in the following cycle; BusyE never asserted.
- Throughput: one operation per 34 cycles (iterative) or 2 cycles (early out); back-to-back ops need an IDLE cycle in between.

## Configuration
- MULDIV_FAST_MUL_EN defined: all four multiply ops use a single-cycle 33x33 signed multiplier and go IDLE -> DONE at edge 0, like early-out ops. BusyE is never asserted for multiplies. Divide behaviour is unchanged.
- Undefined: multiplies use the 32-iteration shift-add path described above.

## Test plan
- MUL: SrcAE=7, SrcBE=0xFFFFFFFD (-3), StartE 1 cycle -> BusyE high 33 cycles, DoneE pulse, ResultE=0xFFFFFFEB. With MULDIV_FAST_MUL_EN, DoneE follows 1 edge later with the same result.
- MULH/MULHU: A=B=0x80000000 -> MULH=0x40000000, MULHU=0x40000000. MULHSU with A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF.
- DIV/REM signs: A=-7 (0xFFFFFFF9), B=2 -> DIV=0xFFFFFFFD, REM=0xFFFFFFFF. DIVU with the same operands -> 0x7FFFFFFC.
- Early out, with BusyE=0 throughout and DoneE the next cycle:
  - DIV A=5, B=0 -> 0xFFFFFFFF.
  - REMU A=5, B=0 -> 5.
  - DIV A=0x80000000, B=-1 -> 0x80000000.
- Abort: start DIVU 100/3, assert FlushE at CALC iteration 10 -> IDLE next edge, no DoneE, ResultE keeps its prior value. A new REMU 100/3 then returns 1.
- Reset: drop rst to 0 mid-CALC -> BusyE=0, DoneE=0 and ResultE=0 immediately. After release, StartE with A=B=0 for MUL returns 0.
